// File: rtl/ctrl_unit_mc_pkg.sv
// Shared encodings for the multicycle control unit: state codes, instruction
// fields and datapath select/operation codes.
package ctrl_pkg;

  localparam int unsigned STATE_W  = 5;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned SRCA_W   = 2;
  localparam int unsigned SRCB_W   = 3;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned PCSRC_W  = 2;
  localparam int unsigned REGDST_W = 2;
  localparam int unsigned M2R_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_IR_LD      = 5'd3,
    S_DECODE     = 5'd4,
    S_EXEC_R     = 5'd5,
    S_WB_R       = 5'd6,
    S_ADDR       = 5'd7,
    S_LW_RD      = 5'd8,
    S_LW_WAIT    = 5'd9,
    S_LW_LD      = 5'd10,
    S_LW_WB      = 5'd11,
    S_SW_WR      = 5'd12,
    S_ADDI_EX    = 5'd13,
    S_ADDI_WB    = 5'd14,
    S_BEQ        = 5'd15,
    S_JUMP       = 5'd16
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;

  localparam logic [SRCA_W-1:0] SRCA_PC = 2'b00;
  localparam logic [SRCA_W-1:0] SRCA_A  = 2'b01;

  localparam logic [SRCB_W-1:0] SRCB_RT     = 3'b000;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 3'b001;
  localparam logic [SRCB_W-1:0] SRCB_OFFSET = 3'b010;
  localparam logic [SRCB_W-1:0] SRCB_MDR    = 3'b011;
  localparam logic [SRCB_W-1:0] SRCB_DESLOC = 3'b100;

  localparam logic [ALUOP_W-1:0] ALU_NONE = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 3'b011;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [REGDST_W-1:0] REGDST_RT = 2'b00;
  localparam logic [REGDST_W-1:0] REGDST_RD = 2'b01;

  localparam logic [M2R_W-1:0] M2R_ALUOUT = 2'b00;
  localparam logic [M2R_W-1:0] M2R_MDR    = 2'b01;

endpackage

// File: rtl/ctrl_unit_mc_wait_cnt.sv
// Memory wait-cycle counter shared by the fetch and load wait states;
// done flags the last wait cycle.
module ctrl_wait_cnt #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= 2'd0;
    else if (en)      cnt <= cnt + 2'd1;
  end

  assign done = (cnt == 2'(LIMIT - 1));

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multicycle control unit: Moore sequencer over fetch/decode/execute/memory/
// writeback, with the branch pc_write taken from the ALU zero flag.
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode,
  input  logic [OP_W-1:0]     funct,
  input  logic                zero,
  output logic [SRCA_W-1:0]   alu_src_a,
  output logic [SRCB_W-1:0]   alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                pc_write,
  output logic [PCSRC_W-1:0]  pc_src,
  output logic                iord,
  output logic                mem_wr,
  output logic                ir_write,
  output logic                mdr_load,
  output logic                ab_load,
  output logic                alu_out_load,
  output logic                reg_write,
  output logic [REGDST_W-1:0] reg_dst,
  output logic [M2R_W-1:0]    mem_to_reg,
  output logic [STATE_W-1:0]  state_o
);

  state_t state, next_state;
  logic   cnt_clr, cnt_en, cnt_done;

  ctrl_wait_cnt #(.LIMIT(MEM_WAIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .done  (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_RESET;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = S_FETCH;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RT;
    alu_op       = ALU_NONE;
    pc_write     = 1'b0;
    pc_src       = PCSRC_ALU;
    iord         = 1'b0;
    mem_wr       = 1'b0;
    ir_write     = 1'b0;
    mdr_load     = 1'b0;
    ab_load      = 1'b0;
    alu_out_load = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = REGDST_RT;
    mem_to_reg   = M2R_ALUOUT;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALU_ADD;
        pc_write   = 1'b1;
        cnt_clr    = 1'b1;
        next_state = (MEM_WAIT == 0) ? S_IR_LD : S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        cnt_en     = 1'b1;
        next_state = cnt_done ? S_IR_LD : S_FETCH_WAIT;
      end
      S_IR_LD: begin
        ir_write   = 1'b1;
        next_state = S_DECODE;
      end
      // ALUOut captures the branch target while A/B load.
      S_DECODE: begin
        ab_load      = 1'b1;
        alu_src_b    = SRCB_DESLOC;
        alu_op       = ALU_ADD;
        alu_out_load = 1'b1;
        case (opcode)
          OP_RTYPE:     next_state = S_EXEC_R;
          OP_LW, OP_SW: next_state = S_ADDR;
          OP_ADDI:      next_state = S_ADDI_EX;
          OP_BEQ:       next_state = S_BEQ;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_RT;
        alu_out_load = 1'b1;
        next_state   = S_WB_R;
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          default: begin
            alu_out_load = 1'b0;
            next_state   = S_FETCH;
          end
        endcase
      end
      S_WB_R: begin
        reg_dst   = REGDST_RD;
        reg_write = 1'b1;
      end
      S_ADDR: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_OFFSET;
        alu_op       = ALU_ADD;
        alu_out_load = 1'b1;
        next_state   = (opcode == OP_LW) ? S_LW_RD : S_SW_WR;
      end
      S_LW_RD: begin
        iord       = 1'b1;
        cnt_clr    = 1'b1;
        next_state = (MEM_WAIT == 0) ? S_LW_LD : S_LW_WAIT;
      end
      S_LW_WAIT: begin
        cnt_en     = 1'b1;
        next_state = cnt_done ? S_LW_LD : S_LW_WAIT;
      end
      S_LW_LD: begin
        mdr_load   = 1'b1;
        next_state = S_LW_WB;
      end
      S_LW_WB: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
      end
      S_SW_WR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_OFFSET;
        alu_op       = ALU_ADD;
        alu_out_load = 1'b1;
        next_state   = S_ADDI_WB;
      end
      S_ADDI_WB: reg_write = 1'b1;
      // Branch resolves in this cycle from the live zero flag.
      S_BEQ: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Directed bench for ctrl_unit_mc: three instances (MEM_WAIT 1..3) share
// stimulus; each test resynchronises them with a reset and walks one instance.
module tb_ctrl_unit_mc;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic [1:0] alu_src_a    [1:3];
  logic [2:0] alu_src_b    [1:3];
  logic [2:0] alu_op       [1:3];
  logic       pc_write     [1:3];
  logic [1:0] pc_src       [1:3];
  logic       iord         [1:3];
  logic       mem_wr       [1:3];
  logic       ir_write     [1:3];
  logic       mdr_load     [1:3];
  logic       ab_load      [1:3];
  logic       alu_out_load [1:3];
  logic       reg_write    [1:3];
  logic [1:0] reg_dst      [1:3];
  logic [1:0] mem_to_reg   [1:3];
  logic [4:0] state_o      [1:3];

  int n_checks = 0;
  int n_err    = 0;
  int exp_r_op = 1;
  int seq[$];

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    ctrl_unit_mc #(.MEM_WAIT(g)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .funct        (funct),
      .zero         (zero),
      .alu_src_a    (alu_src_a[g]),
      .alu_src_b    (alu_src_b[g]),
      .alu_op       (alu_op[g]),
      .pc_write     (pc_write[g]),
      .pc_src       (pc_src[g]),
      .iord         (iord[g]),
      .mem_wr       (mem_wr[g]),
      .ir_write     (ir_write[g]),
      .mdr_load     (mdr_load[g]),
      .ab_load      (ab_load[g]),
      .alu_out_load (alu_out_load[g]),
      .reg_write    (reg_write[g]),
      .reg_dst      (reg_dst[g]),
      .mem_to_reg   (mem_to_reg[g]),
      .state_o      (state_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves all instances in FETCH.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Walks instance inst through the expected state list in seq, checking
  // state-specific outputs each cycle; ends sitting in the last listed state.
  task automatic walk(input int inst, input string name);
    for (int i = 0; i < seq.size(); i++) begin
      int    e;
      int    busy;
      string t;
      e = seq[i];
      t = $sformatf("%s[%0d]", name, i);
      chk({t, ".state"}, 32'(state_o[inst]), 32'(e));
      chk({t, ".mem_wr"}, 32'(mem_wr[inst]), 32'(e == 12));
      chk({t, ".reg_write"}, 32'(reg_write[inst]), 32'(e == 6 || e == 11 || e == 14));
      chk({t, ".ir_write"}, 32'(ir_write[inst]), 32'(e == 3));
      chk({t, ".pc_write"}, 32'(pc_write[inst]),
          32'(e == 1 || e == 16 || (e == 15 && zero)));
      busy = int'(pc_write[inst]) + int'(ir_write[inst]) + int'(mem_wr[inst]) +
             int'(reg_write[inst]);
      chk({t, ".excl"}, 32'(busy <= 1), 32'd1);
      case (e)
        1:  chk({t, ".src_b"}, 32'(alu_src_b[inst]), 32'd1);
        4: begin
          chk({t, ".src_b"}, 32'(alu_src_b[inst]), 32'd4);
          chk({t, ".ab_load"}, 32'(ab_load[inst]), 32'd1);
        end
        5: begin
          chk({t, ".alu_op"}, 32'(alu_op[inst]), 32'(exp_r_op));
          chk({t, ".alu_out_load"}, 32'(alu_out_load[inst]), 32'(exp_r_op != 0));
        end
        6:  chk({t, ".reg_dst"}, 32'(reg_dst[inst]), 32'd1);
        7:  chk({t, ".src_b"}, 32'(alu_src_b[inst]), 32'd2);
        11: chk({t, ".mem_to_reg"}, 32'(mem_to_reg[inst]), 32'd1);
        12: chk({t, ".iord"}, 32'(iord[inst]), 32'd1);
        15: chk({t, ".pc_src"}, 32'(pc_src[inst]), 32'd1);
        default: ;
      endcase
      if (i != seq.size() - 1) tick();
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h20;
    zero   = 1'b0;

    // Reset held two cycles: everything idle.
    tick();
    tick();
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("rst%0d.state", k), 32'(state_o[k]), 32'd0);
      chk($sformatf("rst%0d.pc_write", k), 32'(pc_write[k]), 32'd0);
    end
    chk("rst.src_b", 32'(alu_src_b[1]), 32'd0);
    chk("rst.alu_op", 32'(alu_op[1]), 32'd0);
    chk("rst.ab_load", 32'(ab_load[1]), 32'd0);
    reset = 1'b0;
    chk("rel0.state", 32'(state_o[1]), 32'd0);
    tick();
    chk("rel1.state", 32'(state_o[1]), 32'd1);
    chk("rel1.pc_write", 32'(pc_write[1]), 32'd1);
    chk("rel1.src_b", 32'(alu_src_b[1]), 32'd1);

    // add, W=1
    opcode = 6'h00; funct = 6'h20; exp_r_op = 1;
    do_reset();
    seq = '{1, 2, 3, 4, 5, 6, 1};
    walk(1, "add");

    // sub and and, W=1
    funct = 6'h22; exp_r_op = 2;
    do_reset();
    seq = '{1, 2, 3, 4, 5, 6, 1};
    walk(1, "sub");
    funct = 6'h24; exp_r_op = 3;
    do_reset();
    walk(1, "and");

    // lw, W=3
    opcode = 6'h23;
    do_reset();
    seq = '{1, 2, 2, 2, 3, 4, 7, 8, 9, 9, 9, 10, 11, 1};
    walk(3, "lw3");

    // addi and j, W=1
    opcode = 6'h08;
    do_reset();
    seq = '{1, 2, 3, 4, 13, 14, 1};
    walk(1, "addi");
    opcode = 6'h02;
    do_reset();
    seq = '{1, 2, 3, 4, 16, 1};
    walk(1, "j");
    chk("j.pc_src", 32'(pc_src[1]), 32'd0);

    // beq taken and not taken, W=1
    opcode = 6'h04; zero = 1'b1;
    do_reset();
    seq = '{1, 2, 3, 4, 15, 1};
    walk(1, "beq_t");
    zero = 1'b0;
    do_reset();
    walk(1, "beq_n");

    // Unknown opcode behaves as NOP
    opcode = 6'h3F;
    do_reset();
    seq = '{1, 2, 3, 4, 1};
    walk(1, "nop_op");

    // Unknown funct aborts after EXEC_R
    opcode = 6'h00; funct = 6'h27; exp_r_op = 0;
    do_reset();
    seq = '{1, 2, 3, 4, 5, 1};
    walk(1, "nop_fn");

    // Reset in the first LW_WAIT cycle, W=2
    opcode = 6'h23;
    do_reset();
    seq = '{1, 2, 2, 3, 4, 7, 8, 9};
    walk(2, "lw2");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst.state", 32'(state_o[2]), 32'd0);
    chk("midrst.iord", 32'(iord[2]), 32'd0);
    tick();
    chk("midrst.fetch", 32'(state_o[2]), 32'd1);

    // sw immediately after, W=1: six cycles
    opcode = 6'h2B;
    seq = '{1, 2, 3, 4, 7, 12, 1};
    walk(1, "sw");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
